// File: rtl/fractal_sync_pkg.sv
// Shared definitions for the fractal sync tree node: transmit FSM states,
// port numbering and small helpers used by the tx block and its arbiter.
package fractal_sync_pkg;

   // Transmit-side FSM states.
   typedef enum logic {
      TX_IDLE = 1'b0,
      TX_GAP  = 1'b1
   } tx_state_e;

   // Port numbering. Matches the receiver-side SD mask bit ordering.
   localparam int unsigned TX_PORT_R = 0;
   localparam int unsigned TX_PORT_L = 1;

   // One-hot strobe for a two-port index (0 -> 2'b01, 1 -> 2'b10).
   function automatic logic [1:0] tx_port_onehot(input logic port);
      logic [1:0] oh;
      if (port) begin
         oh = 2'b10;
      end else begin
         oh = 2'b01;
      end
      return oh;
   endfunction

endpackage

// File: rtl/fractal_sync_rr_arb.sv
// Two-input round-robin arbiter. The priority pointer names the preferred
// port; after an accepted grant (update_i with a pending request) it moves
// to the port that was not granted. Reusable by the node's response path.
module fractal_sync_rr_arb
   import fractal_sync_pkg::*;
#(
   parameter bit RR_INIT = 1'b0
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] req_i,
   input  logic       update_i,
   output logic [1:0] gnt_o,
   output logic       gnt_idx_o
);

   logic prio_q;
   logic prio_d;

   // Grant selection: preferred port if requesting, otherwise the other one.
   always_comb begin
      gnt_idx_o = prio_q;
      gnt_o     = 2'b00;
      if (req_i[prio_q]) begin
         gnt_idx_o = prio_q;
      end else if (req_i[~prio_q]) begin
         gnt_idx_o = ~prio_q;
      end else begin
         gnt_idx_o = prio_q;
      end
      if (|req_i) begin
         gnt_o = tx_port_onehot(gnt_idx_o);
      end else begin
         gnt_o = 2'b00;
      end
   end

   // Pointer next state: move past the granted port only on an accepted grant.
   always_comb begin
      prio_d = prio_q;
      if (update_i && (|req_i)) begin
         prio_d = ~gnt_idx_o;
      end else begin
         prio_d = prio_q;
      end
   end

   // Priority pointer register.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         prio_q <= RR_INIT;
      end else begin
         prio_q <= prio_d;
      end
   end

endmodule

// File: rtl/fractal_sync_tx.sv
// Transmit side of a fractal sync tree node. Drains the right and left
// request queues through a round-robin arbiter and emits one registered,
// single-cycle request pulse per valid pop. The downstream receiver has no
// backpressure, so this block enforces a minimum idle gap between pulses
// and flags (and drops) queue heads whose sync bit is clear.
// The request type must be a packed type whose leading (MSB) field is sync;
// only that bit is interpreted here, all other fields pass through untouched.
module fractal_sync_tx
   import fractal_sync_pkg::*;
#(
   parameter type         fsync_req_t = logic,
   parameter int unsigned SEND_GAP    = 0,
   parameter bit          RR_INIT     = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [1:0]       empty_i,
   input  fsync_req_t [1:0] req_i,
   output logic [1:0]       pop_o,
   output fsync_req_t       req_o,
   output logic             busy_o,
   output logic             error_invalid_o,
   output logic             grant_o
);

   localparam int unsigned REQ_W    = $bits(fsync_req_t);
   localparam int unsigned SYNC_BIT = REQ_W - 1;
   localparam int unsigned CNT_W    = ($clog2(SEND_GAP + 1) > 0) ? $clog2(SEND_GAP + 1) : 1;
   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(SEND_GAP);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   tx_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [REQ_W-1:0] req_q, req_d;
   logic             err_q, err_d;
   logic             grant_q, grant_d;

   logic [1:0]       cand_s;
   logic [1:0]       gnt_s;
   logic             gnt_idx_s;
   logic [REQ_W-1:0] head_s;

   // Only IDLE may pop; a non-empty queue is a candidate.
   assign cand_s = (state_q == TX_IDLE) ? ~empty_i : 2'b00;

   fractal_sync_rr_arb #(
      .RR_INIT (RR_INIT)
   ) u_arb (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .req_i     (cand_s),
      .update_i  (|cand_s),
      .gnt_o     (gnt_s),
      .gnt_idx_o (gnt_idx_s)
   );

   // Pop is combinational in the grant cycle and suppressed while in reset.
   assign pop_o           = rst_ni ? gnt_s : 2'b00;
   assign head_s          = req_i[gnt_idx_s];
   assign req_o           = req_q;
   assign error_invalid_o = err_q;
   assign grant_o         = grant_q;
   assign busy_o          = (state_q == TX_GAP) | (empty_i != 2'b11);

   // Next-state logic: send or drop the granted head, then pace via GAP.
   always_comb begin
      state_d           = state_q;
      cnt_d             = cnt_q;
      req_d             = req_q;
      req_d[SYNC_BIT]   = 1'b0;
      err_d             = 1'b0;
      grant_d           = grant_q;
      case (state_q)
         TX_IDLE: begin
            if (|cand_s) begin
               grant_d = gnt_idx_s;
               if (head_s[SYNC_BIT]) begin
                  req_d = head_s;
                  if (SEND_GAP > 0) begin
                     state_d = TX_GAP;
                     cnt_d   = GAP_LOAD;
                  end else begin
                     state_d = TX_IDLE;
                  end
               end else begin
                  // Malformed head: dropped, flagged, and no pacing gap.
                  err_d = 1'b1;
               end
            end else begin
               state_d = TX_IDLE;
            end
         end
         TX_GAP: begin
            if (cnt_q <= CNT_ONE) begin
               state_d = TX_IDLE;
               cnt_d   = {CNT_W{1'b0}};
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d = TX_IDLE;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase
   end

   // State and registered outputs; reset aborts any pulse or gap in progress.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= TX_IDLE;
         cnt_q   <= {CNT_W{1'b0}};
         req_q   <= {REQ_W{1'b0}};
         err_q   <= 1'b0;
         grant_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         err_q   <= err_d;
         grant_q <= grant_d;
      end
   end

endmodule

// File: tb/tb_fractal_sync_tx.sv
// Self-checking bench for fractal_sync_tx. Two instances share the clock:
// dut0 with SEND_GAP=0/RR_INIT=0 and dut1 with SEND_GAP=2/RR_INIT=1. The
// bench owns the queues; a reference model tracks the arbitration pointer
// and the earliest cycle at which the next pop is allowed.
module tb_fractal_sync_tx;

   typedef struct packed {
      logic [2:0] aggr;
      logic [4:0] id;
   } fsync_sig_t;

   typedef struct packed {
      logic       sync;
      fsync_sig_t sig;
      logic [1:0] src;
   } fsync_req_t;

   localparam int RW    = $bits(fsync_req_t);
   localparam int DEPTH = 64;

   logic clk = 1'b0;
   logic rst_n;

   logic [1:0]       empty_s [2];
   fsync_req_t [1:0] req_s   [2];
   logic [1:0]       pop_s   [2];
   fsync_req_t       reqo_s  [2];
   logic             busy_s  [2];
   logic             err_s   [2];
   logic             grant_s [2];

   always #5 clk = ~clk;

   fractal_sync_tx #(.fsync_req_t(fsync_req_t), .SEND_GAP(0), .RR_INIT(1'b0)) dut0 (
      .clk_i(clk), .rst_ni(rst_n), .empty_i(empty_s[0]), .req_i(req_s[0]),
      .pop_o(pop_s[0]), .req_o(reqo_s[0]), .busy_o(busy_s[0]),
      .error_invalid_o(err_s[0]), .grant_o(grant_s[0]));

   fractal_sync_tx #(.fsync_req_t(fsync_req_t), .SEND_GAP(2), .RR_INIT(1'b1)) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .empty_i(empty_s[1]), .req_i(req_s[1]),
      .pop_o(pop_s[1]), .req_o(reqo_s[1]), .busy_o(busy_s[1]),
      .error_invalid_o(err_s[1]), .grant_o(grant_s[1]));

   // Bench-owned queues, reference model state and counters.
   fsync_req_t fifo_mem [2][2][DEPTH];
   int         fifo_cnt [2][2];
   int         fifo_rd  [2][2];
   logic [1:0] hide     [2];
   int         gap_len  [2];
   logic       rr_init  [2];
   longint     cyc;
   longint     elig     [2];
   logic       ptr      [2];
   fsync_req_t exp_req  [2];
   logic       exp_err  [2];
   logic       exp_grant[2];
   int         checks;
   int         failures;

   task automatic chk(input string tag, input int k, input logic [15:0] obs, input logic [15:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, expv);
      end
   endtask

   function automatic fsync_req_t mk(input logic s, input logic [2:0] a, input logic [4:0] i, input logic [1:0] sr);
      fsync_req_t r;
      r.sync = s; r.sig.aggr = a; r.sig.id = i; r.src = sr;
      return r;
   endfunction

   task automatic push(input int k, input int n, input fsync_req_t v);
      if (fifo_cnt[k][n] < DEPTH) begin
         fifo_mem[k][n][(fifo_rd[k][n] + fifo_cnt[k][n]) % DEPTH] = v;
         fifo_cnt[k][n]++;
      end
   endtask

   // One clock cycle: drive queues, check pops, predict and check registered outputs.
   task automatic step(input logic rst_val);
      logic [1:0]       vis [2];
      logic [1:0]       ep;
      logic             g;
      fsync_req_t       h;
      logic [RW-1:0]    junk;
      rst_n = rst_val;
      for (int k = 0; k < 2; k++) begin
         for (int n = 0; n < 2; n++) begin
            vis[k][n]     = (fifo_cnt[k][n] > 0) && !hide[k][n];
            empty_s[k][n] = ~vis[k][n];
            junk          = RW'($urandom);
            req_s[k][n]   = vis[k][n] ? fifo_mem[k][n][fifo_rd[k][n]] : fsync_req_t'(junk);
         end
      end
      #2;
      for (int k = 0; k < 2; k++) begin
         ep = 2'b00;
         g  = ptr[k];
         if (rst_val && (cyc >= elig[k]) && (vis[k] != 2'b00)) begin
            g     = vis[k][ptr[k]] ? ptr[k] : ~ptr[k];
            ep[g] = 1'b1;
         end
         chk("pop", k, 16'(pop_s[k]), 16'(ep));
         if (rst_val) begin
            chk("busy", k, 16'(busy_s[k]), 16'((cyc < elig[k]) || (vis[k] != 2'b00)));
         end
         if (!rst_val) begin
            exp_req[k]   = '0;
            exp_err[k]   = 1'b0;
            exp_grant[k] = 1'b0;
            ptr[k]       = rr_init[k];
            elig[k]      = 0;
         end else begin
            exp_req[k].sync = 1'b0;
            exp_err[k]      = 1'b0;
            if (ep != 2'b00) begin
               h = fifo_mem[k][g][fifo_rd[k][g]];
               if (h.sync) begin
                  exp_req[k] = h;
                  elig[k]    = cyc + 1 + gap_len[k];
               end else begin
                  exp_err[k] = 1'b1;
               end
               ptr[k]       = ~g;
               exp_grant[k] = g;
               fifo_rd[k][g]  = (fifo_rd[k][g] + 1) % DEPTH;
               fifo_cnt[k][g] = fifo_cnt[k][g] - 1;
            end
         end
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("req", k, 16'(reqo_s[k]), 16'(exp_req[k]));
         chk("err", k, 16'(err_s[k]), 16'(exp_err[k]));
         chk("grant", k, 16'(grant_s[k]), 16'(exp_grant[k]));
      end
      cyc++;
   endtask

   initial begin
      fsync_req_t t1;
      checks = 0; failures = 0; cyc = 0;
      gap_len[0] = 0; gap_len[1] = 2;
      rr_init[0] = 1'b0; rr_init[1] = 1'b1;
      for (int k = 0; k < 2; k++) begin
         hide[k] = 2'b00; elig[k] = 0; ptr[k] = rr_init[k];
         exp_req[k] = '0; exp_err[k] = 1'b0; exp_grant[k] = 1'b0;
         for (int n = 0; n < 2; n++) begin
            fifo_cnt[k][n] = 0; fifo_rd[k][n] = 0;
         end
      end
      rst_n = 1'b0;
      @(posedge clk);
      #1;

      // Reset state.
      step(1'b0);
      step(1'b0);

      // Single right entry with no gap: pulse one cycle after the pop.
      t1 = mk(1'b1, 3'b010, 5'd5, 2'b01);
      push(0, 0, t1);
      step(1'b1);
      chk("t1_req", 0, 16'(reqo_s[0]), 16'(t1));
      step(1'b1);
      chk("t1_sync_low", 0, 16'(reqo_s[0].sync), 16'(1'b0));

      // Both queues three deep: alternating grants, back-to-back on dut0.
      step(1'b0);
      for (int i = 0; i < 3; i++) begin
         for (int k = 0; k < 2; k++) begin
            push(k, 0, mk(1'b1, 3'(i), 5'(i), 2'b00));
            push(k, 1, mk(1'b1, 3'(i + 4), 5'(i + 16), 2'b11));
         end
      end
      for (int i = 0; i < 20; i++) step(1'b1);

      // Gap pacing on dut1: three right entries.
      for (int i = 0; i < 3; i++) push(1, 0, mk(1'b1, 3'b001, 5'(i + 8), 2'b10));
      for (int i = 0; i < 10; i++) step(1'b1);

      // Invalid left head followed by a valid entry.
      for (int k = 0; k < 2; k++) begin
         push(k, 1, mk(1'b0, 3'b111, 5'd31, 2'b11));
         push(k, 1, mk(1'b1, 3'b011, 5'd9, 2'b01));
      end
      for (int i = 0; i < 6; i++) step(1'b1);

      // Reset while dut1 is in its gap with an entry still pending.
      push(1, 0, mk(1'b1, 3'b100, 5'd20, 2'b01));
      push(1, 0, mk(1'b1, 3'b101, 5'd21, 2'b10));
      step(1'b1);
      step(1'b1);
      step(1'b0);
      chk("rst_gap_req", 1, 16'(reqo_s[1]), 16'(0));
      for (int i = 0; i < 4; i++) step(1'b1);

      // Random queue fill and empty-flag toggling with sparse resets.
      for (int i = 0; i < 3000; i++) begin
         for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 2; n++) begin
               hide[k][n] = ($urandom_range(3) == 0);
               if (($urandom_range(2) == 0) && (fifo_cnt[k][n] < DEPTH - 2)) begin
                  push(k, n, mk($urandom_range(7) != 0, 3'($urandom), 5'($urandom), 2'($urandom)));
               end
            end
         end
         step($urandom_range(499) != 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
